irq_trigger_gen: RTL and testbench
==================================

# irq_trigger_gen

Parametrised, address-triggered interrupt stimulus generator for CPU-level interrupt testing. It watches the CPU's macroscopic PC and holds a table of trigger entries. When an armed entry's address matches, it raises one of several hardware interrupt lines for a programmed number of cycles. It sits between the bench or debug controller and the CPU's external interrupt inputs (HWInt lines), and generalises a fixed single-line, fixed-width injector to multiple channels, per-entry pulse lengths, a loadable table and optional re-arming.

## Interface
Parameters:
- ADDR_W, 32, width of watched address and table addresses
- DEPTH, 16, number of trigger entries (power of two, ≥2)
- CHANNELS, 6, number of interrupt output lines
- LEN_W, 8, width of per-entry pulse length

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- addr_i  in  ADDR_W  CPU macroscopic PC, sampled every rising edge
- arm  in  1  global enable; matching suppressed while low
- cfg_we  in  1  table write strobe
- cfg_idx  in  $clog2(DEPTH)  entry index written
- cfg_valid  in  1  entry valid bit written
- cfg_addr  in  ADDR_W  trigger address written
- cfg_chan  in  $clog2(CHANNELS)  target line written; values ≥CHANNELS are clamped to CHANNELS-1
- cfg_len  in  LEN_W  pulse length written
- rearm  in  1  clear all fired flags (only with IRQ_TRIG_REARM_EN)
- irq_o  out  CHANNELS  registered interrupt lines
- busy  out  1  high in ASSERT or GAP
- hit_idx  out  $clog2(DEPTH)  index of most recently fired entry
- fire_cnt  out  16  number of triggers since reset, saturating at 0xFFFF

## Operation
- Each entry holds {valid, fired, addr, chan, len}. On reset: all valid=0, fired=0, irq_o=0, busy=0, hit_idx=0, fire_cnt=0, state IDLE.
- Config write (cfg_we=1) loads the entry and clears its fired flag. It is accepted in any state.
- FSM states: IDLE, ASSERT, GAP.
- **IDLE**
  - Candidates are entries with valid and !fired and addr==addr_i, and arm=1.
  - If there are candidates, the lowest index wins. Set its fired flag, latch chan and len, load counter with max(len,1), update hit_idx, increment fire_cnt, go to ASSERT.
  - Non-winning matching entries stay unfired and may match later.
- **ASSERT**
  - irq_o[chan]=1 and all other bits 0.
  - The counter decrements each cycle. At count 1, go to GAP.
  - Matches are ignored; no fired flags change.
- **GAP**
  - irq_o=0 for exactly one cycle, then IDLE. This guarantees a visible falling edge between back-to-back triggers.
- Same-cycle write and match on the same index: the match uses the pre-write contents. The write then clears fired, so the entry re-arms.
- Dropping arm during ASSERT does not truncate the pulse.
- Reset mid-ASSERT: irq_o=0 on the next cycle and the table is cleared.

## Timing
- Match sampled at edge N. irq_o goes high after edge N+1 (one-cycle latency) and stays high for max(len,1) cycles. GAP takes 1 cycle. The earliest next assertion is 2 cycles after deassertion.
- busy goes high in the same cycle irq_o rises and drops when GAP exits.
- hit_idx and fire_cnt update together with the ASSERT entry.
- Config writes take effect for matching at the following edge.

## Configuration
- IRQ_TRIG_REARM_EN
  - Defined: rearm=1 at an edge clears every fired flag. It has no effect on an in-progress pulse. If rearm coincides with an IDLE match, the winner's fired flag is still set.
  - Undefined: the rearm port exists but is ignored. Fired flags clear only on reset or a per-entry config write, so every entry fires at most once per load.

## Test plan
- Load entry 0 {addr=0x308c, chan=0, len=5}, arm=1, drive addr_i=0x308c for 1 cycle -> irq_o=6'b000001 for 5 cycles starting 1 cycle later, fire_cnt=1, hit_idx=0. Re-presenting 0x308c later gives no pulse.
- Entries 3 and 7 both set to addr 0x30c0 (chan 2, chan 5) -> entry 3 fires on bit 2. On the next visit to 0x30c0 after GAP, entry 7 fires on bit 5.
- len=0 on entry 1 -> exactly 1-cycle pulse. len=255 -> 255-cycle pulse. A matching address presented during the pulse is ignored and fires on its next visit.
- arm=0 while addr_i hits a valid entry -> irq_o stays 0 and fired is unchanged. After arm=1 and a revisit, it fires normally.
- Assert reset during cycle 3 of a 10-cycle pulse -> irq_o=0, busy=0 and fire_cnt=0 after the next edge. The old address no longer triggers.
- With IRQ_TRIG_REARM_EN: fire entry 0, pulse rearm, revisit 0x308c -> second pulse and fire_cnt=2. Without the macro: no second pulse.

Source files
------------

// File: rtl/irq_trigger_gen.sv
// irq_trigger_gen
//
// Address-triggered interrupt stimulus generator. The generator watches the
// CPU macroscopic PC and compares it against a table of trigger entries. When
// an armed entry matches, the generator drives one of CHANNELS interrupt lines
// high for a programmed number of cycles. It then holds all lines low for one
// cycle before it accepts the next trigger.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (clears table, counters, FSM)
//   addr_i     watched PC, registered every edge before matching
//   arm        global match enable, registered alongside addr_i
//   cfg_we     table write strobe; loads one entry and clears its fired flag
//   cfg_idx    entry index to write
//   cfg_valid  valid bit to write
//   cfg_addr   trigger address to write
//   cfg_chan   target line to write (values >= CHANNELS clamp to CHANNELS-1)
//   cfg_len    pulse length to write (0 behaves as 1)
//   rearm      clears all fired flags (only with IRQ_TRIG_REARM_EN)
//   irq_o      registered interrupt lines, one-hot while a pulse is active
//   busy       high while a pulse or its trailing gap is in progress
//   hit_idx    index of the most recently fired entry
//   fire_cnt   triggers since reset, saturating at 16'hFFFF
//
// Build option
//   IRQ_TRIG_REARM_EN  when defined, the rearm input clears every fired flag.
//                      When undefined, rearm is ignored and each entry fires at
//                      most once per load.
//
// FSM
//   state    | meaning
//   S_IDLE   | waiting for an armed, unfired, valid entry to match addr_q
//   S_ASSERT | irq_o[chan_q] high, counting the pulse length down
//   S_GAP    | one cycle with all lines low, then back to S_IDLE

module irq_trigger_gen #(
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 16,
    parameter int CHANNELS = 6,
    parameter int LEN_W    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           addr_i,
    input  logic                        arm,
    input  logic                        cfg_we,
    input  logic [$clog2(DEPTH)-1:0]    cfg_idx,
    input  logic                        cfg_valid,
    input  logic [ADDR_W-1:0]           cfg_addr,
    input  logic [$clog2(CHANNELS)-1:0] cfg_chan,
    input  logic [LEN_W-1:0]            cfg_len,
    input  logic                        rearm,
    output logic [CHANNELS-1:0]         irq_o,
    output logic                        busy,
    output logic [$clog2(DEPTH)-1:0]    hit_idx,
    output logic [15:0]                 fire_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(CHANNELS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]   addr_q;
    logic                arm_q;

    logic                tab_valid_q [DEPTH];
    logic                tab_fired_q [DEPTH];
    logic [ADDR_W-1:0]   tab_addr_q  [DEPTH];
    logic [CW-1:0]       tab_chan_q  [DEPTH];
    logic [LEN_W-1:0]    tab_len_q   [DEPTH];

    logic [CW-1:0]       chan_q, chan_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]       hit_idx_q, hit_idx_d;
    logic [15:0]         fire_cnt_q, fire_cnt_d;
    logic [CHANNELS-1:0] irq_q, irq_d;

    logic                cand_hit;
    logic [IW-1:0]       cand_idx;
    logic                match_go;
    logic [CW-1:0]       cfg_chan_clamped;
    logic                rearm_clr;

`ifdef IRQ_TRIG_REARM_EN
    assign rearm_clr = rearm;
`else
    logic unused_rearm;
    assign rearm_clr    = 1'b0;
    assign unused_rearm = rearm;
`endif

    assign cfg_chan_clamped = (cfg_chan > CW'(CHANNELS - 1)) ? CW'(CHANNELS - 1) : cfg_chan;

    // PC and arm are registered first, so a match seen at edge N becomes a
    // pulse after edge N+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            arm_q  <= 1'b0;
        end else begin
            addr_q <= addr_i;
            arm_q  <= arm;
        end
    end

    // Scanning downward lets the lowest matching index overwrite the others.
    always_comb begin
        cand_hit = 1'b0;
        cand_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tab_valid_q[i] && !tab_fired_q[i] && (tab_addr_q[i] == addr_q)) begin
                cand_hit = 1'b1;
                cand_idx = IW'(i);
            end
        end
    end

    assign match_go = (state_q == S_IDLE) && arm_q && cand_hit;

    // A config write beats the fired-set of a same-edge match. The match has
    // already used the old contents, and the rewritten entry comes back armed.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_valid_q[i] <= 1'b0;
                tab_fired_q[i] <= 1'b0;
                tab_addr_q[i]  <= '0;
                tab_chan_q[i]  <= '0;
                tab_len_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cfg_we && (cfg_idx == IW'(i))) begin
                    tab_valid_q[i] <= cfg_valid;
                    tab_fired_q[i] <= 1'b0;
                    tab_addr_q[i]  <= cfg_addr;
                    tab_chan_q[i]  <= cfg_chan_clamped;
                    tab_len_q[i]   <= cfg_len;
                end else if (match_go && (cand_idx == IW'(i))) begin
                    tab_fired_q[i] <= 1'b1;
                end else if (rearm_clr) begin
                    tab_fired_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            chan_q     <= '0;
            cnt_q      <= '0;
            hit_idx_q  <= '0;
            fire_cnt_q <= '0;
            irq_q      <= '0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            cnt_q      <= cnt_d;
            hit_idx_q  <= hit_idx_d;
            fire_cnt_q <= fire_cnt_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        cnt_d      = cnt_q;
        hit_idx_d  = hit_idx_q;
        fire_cnt_d = fire_cnt_q;
        irq_d      = '0;

        case (state_q)
            S_IDLE: begin
                if (match_go) begin
                    state_d   = S_ASSERT;
                    chan_d    = tab_chan_q[cand_idx];
                    cnt_d     = (tab_len_q[cand_idx] == '0) ? LEN_W'(1) : tab_len_q[cand_idx];
                    hit_idx_d = cand_idx;
                    if (fire_cnt_q != 16'hFFFF) begin
                        fire_cnt_d = fire_cnt_q + 16'd1;
                    end
                end
            end
            S_ASSERT: begin
                if (cnt_q <= LEN_W'(1)) begin
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Lines are registered from the next state, so irq_o is high exactly
        // during the S_ASSERT cycles.
        if (state_d == S_ASSERT) begin
            irq_d = CHANNELS'(1) << chan_d;
        end
    end

    assign irq_o    = irq_q;
    assign busy     = (state_q != S_IDLE);
    assign hit_idx  = hit_idx_q;
    assign fire_cnt = fire_cnt_q;

endmodule

// File: tb/tb_irq_trigger_gen.sv
// Directed testbench for irq_trigger_gen with default parameters.
module tb_irq_trigger_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_i;
    logic        arm;
    logic        cfg_we;
    logic [3:0]  cfg_idx;
    logic        cfg_valid;
    logic [31:0] cfg_addr;
    logic [2:0]  cfg_chan;
    logic [7:0]  cfg_len;
    logic        rearm;
    logic [5:0]  irq_o;
    logic        busy;
    logic [3:0]  hit_idx;
    logic [15:0] fire_cnt;

    int passed = 0;
    int total  = 0;
    int exp_fire = 0;

    irq_trigger_gen dut (
        .clk       (clk),
        .reset     (reset),
        .addr_i    (addr_i),
        .arm       (arm),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_valid (cfg_valid),
        .cfg_addr  (cfg_addr),
        .cfg_chan  (cfg_chan),
        .cfg_len   (cfg_len),
        .rearm     (rearm),
        .irq_o     (irq_o),
        .busy      (busy),
        .hit_idx   (hit_idx),
        .fire_cnt  (fire_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] a, input int ch, input int ln);
        cfg_we    = 1'b1;
        cfg_idx   = 4'(idx);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_chan  = 3'(ch);
        cfg_len   = 8'(ln);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic present(input logic [31:0] a);
        addr_i = a;
        tick();
        addr_i = 32'h0;
    endtask

    // Waits up to budget cycles for a pulse, then measures its width and the
    // gap/idle cycles that follow.
    task automatic measure(input int budget, output bit found, output int lat,
                           output logic [5:0] pat, output int width,
                           output logic [5:0] gap_irq, output bit gap_busy,
                           output bit idle_busy);
        found = 0; lat = 0; pat = '0; width = 0;
        gap_irq = '0; gap_busy = 0; idle_busy = 0;
        while (lat < budget && !found) begin
            tick();
            lat++;
            if (irq_o != 6'h0) found = 1;
        end
        if (found) begin
            pat   = irq_o;
            width = 1;
            tick();
            while (irq_o == pat && width < 400) begin
                width++;
                tick();
            end
            gap_irq  = irq_o;
            gap_busy = busy;
            tick();
            idle_busy = busy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (irq_o !== 6'h0) $display("FAIL reset_irq: got %b expected 000000", irq_o); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (hit_idx !== 4'd0) $display("FAIL reset_hit_idx: got %0d expected 0", hit_idx); else passed++;
        total++; if (fire_cnt !== 16'd0) $display("FAIL reset_fire_cnt: got %0d expected 0", fire_cnt); else passed++;
    endtask

    task automatic test_basic();
        bit f, gb, ib; int lat, w; logic [5:0] p, gi;
        arm = 1'b1;
        load(0, 32'h308c, 0, 5);
        present(32'h308c);
        measure(6, f, lat, p, w, gi, gb, ib);
        exp_fire++;
        total++; if (f !== 1'b1 || lat != 1) $display("FAIL basic_latency: got found=%0d lat=%0d expected found=1 lat=1", f, lat); else passed++;
        total++; if (p !== 6'b000001) $display("FAIL basic_pattern: got %b expected 000001", p); else passed++;
        total++; if (w != 5) $display("FAIL basic_width: got %0d expected 5", w); else passed++;
        total++; if (gi !== 6'h0 || gb !== 1'b1) $display("FAIL basic_gap: got irq=%b busy=%0d expected irq=000000 busy=1", gi, gb); else passed++;
        total++; if (ib !== 1'b0) $display("FAIL basic_idle_busy: got %0d expected 0", ib); else passed++;
        total++; if (fire_cnt !== 16'(exp_fire) || hit_idx !== 4'd0) $display("FAIL basic_counters: got fire=%0d hit=%0d expected fire=%0d hit=0", fire_cnt, hit_idx, exp_fire); else passed++;
        present(32'h308c);
        measure(6, f, lat, p, w, gi, gb, ib);
        total++; if (f !== 1'b0) $display("FAIL basic_once: got pulse %b expected none", p); else passed++;
    endtask

    task automatic test_priority();
        bit f, gb, ib; int lat, w; logic [5:0] p, gi;
        load(3, 32'h30c0, 2, 3);
        load(7, 32'h30c0, 5, 2);
        present(32'h30c0);
        measure(6, f, lat, p, w, gi, gb, ib);
        exp_fire++;
        total++; if (p !== 6'b000100 || w != 3 || hit_idx !== 4'd3) $display("FAIL prio_first: got pat=%b w=%0d hit=%0d expected pat=000100 w=3 hit=3", p, w, hit_idx); else passed++;
        present(32'h30c0);
        measure(6, f, lat, p, w, gi, gb, ib);
        exp_fire++;
        total++; if (p !== 6'b100000 || w != 2 || hit_idx !== 4'd7) $display("FAIL prio_second: got pat=%b w=%0d hit=%0d expected pat=100000 w=2 hit=7", p, w, hit_idx); else passed++;
        total++; if (fire_cnt !== 16'(exp_fire)) $display("FAIL prio_fire_cnt: got %0d expected %0d", fire_cnt, exp_fire); else passed++;
    endtask

    task automatic test_len();
        bit f, gb, ib; int lat, w; logic [5:0] p, gi;
        load(1, 32'h3100, 1, 0);
        present(32'h3100);
        measure(6, f, lat, p, w, gi, gb, ib);
        exp_fire++;
        total++; if (p !== 6'b000010 || w != 1) $display("FAIL len0: got pat=%b w=%0d expected pat=000010 w=1", p, w); else passed++;
        total++; if (gi !== 6'h0 || gb !== 1'b1 || ib !== 1'b0) $display("FAIL len0_gap: got irq=%b busy=%0d idle_busy=%0d expected 000000 1 0", gi, gb, ib); else passed++;

        load(2, 32'h3200, 3, 255);
        load(4, 32'h3300, 4, 2);
        present(32'h3200);
        tick();
        exp_fire++;
        total++; if (irq_o !== 6'b001000) $display("FAIL len255_rise: got %b expected 001000", irq_o); else passed++;
        w = 1;
        for (int k = 0; k < 300; k++) begin
            if (w == 10) addr_i = 32'h3300;
            if (w == 11) addr_i = 32'h0;
            tick();
            if (irq_o == 6'b001000) w++;
            else break;
        end
        total++; if (w != 255) $display("FAIL len255_width: got %0d expected 255", w); else passed++;
        total++; if (irq_o !== 6'h0) $display("FAIL len255_gap: got %b expected 000000", irq_o); else passed++;
        tick();
        measure(5, f, lat, p, w, gi, gb, ib);
        total++; if (f !== 1'b0) $display("FAIL ignore_during_pulse: got pulse %b expected none", p); else passed++;
        present(32'h3300);
        measure(6, f, lat, p, w, gi, gb, ib);
        exp_fire++;
        total++; if (p !== 6'b010000 || w != 2 || hit_idx !== 4'd4) $display("FAIL revisit_fires: got pat=%b w=%0d hit=%0d expected pat=010000 w=2 hit=4", p, w, hit_idx); else passed++;

        load(5, 32'h3400, 7, 1);
        present(32'h3400);
        measure(6, f, lat, p, w, gi, gb, ib);
        exp_fire++;
        total++; if (p !== 6'b100000 || w != 1) $display("FAIL chan_clamp: got pat=%b w=%0d expected pat=100000 w=1", p, w); else passed++;
    endtask

    task automatic test_arm();
        bit f, gb, ib; int lat, w; logic [5:0] p, gi;
        load(6, 32'h3500, 0, 3);
        arm = 1'b0;
        present(32'h3500);
        measure(5, f, lat, p, w, gi, gb, ib);
        total++; if (f !== 1'b0 || busy !== 1'b0) $display("FAIL arm_low: got pulse=%b busy=%0d expected none busy=0", p, busy); else passed++;
        arm = 1'b1;
        present(32'h3500);
        measure(6, f, lat, p, w, gi, gb, ib);
        exp_fire++;
        total++; if (p !== 6'b000001 || w != 3 || hit_idx !== 4'd6) $display("FAIL arm_revisit: got pat=%b w=%0d hit=%0d expected pat=000001 w=3 hit=6", p, w, hit_idx); else passed++;
        total++; if (fire_cnt !== 16'(exp_fire)) $display("FAIL arm_fire_cnt: got %0d expected %0d", fire_cnt, exp_fire); else passed++;
    endtask

    task automatic test_same_cycle();
        bit f, gb, ib; int lat, w; logic [5:0] p, gi;
        load(10, 32'h3800, 3, 2);
        addr_i = 32'h3800;
        tick();
        addr_i    = 32'h0;
        cfg_we    = 1'b1;
        cfg_idx   = 4'd10;
        cfg_valid = 1'b1;
        cfg_addr  = 32'h3900;
        cfg_chan  = 3'd0;
        cfg_len   = 8'd1;
        tick();
        cfg_we = 1'b0;
        exp_fire++;
        total++; if (irq_o !== 6'b001000 || hit_idx !== 4'd10) $display("FAIL same_cycle_old: got irq=%b hit=%0d expected irq=001000 hit=10", irq_o, hit_idx); else passed++;
        repeat (4) tick();
        present(32'h3900);
        measure(6, f, lat, p, w, gi, gb, ib);
        exp_fire++;
        total++; if (p !== 6'b000001 || w != 1) $display("FAIL same_cycle_rearmed: got pat=%b w=%0d expected pat=000001 w=1", p, w); else passed++;
    endtask

    task automatic test_rearm();
        bit f, gb, ib; int lat, w; logic [5:0] p, gi;
        load(0, 32'h308c, 0, 2);
        present(32'h308c);
        measure(6, f, lat, p, w, gi, gb, ib);
        exp_fire++;
        total++; if (p !== 6'b000001 || w != 2) $display("FAIL rearm_first: got pat=%b w=%0d expected pat=000001 w=2", p, w); else passed++;
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        present(32'h308c);
        measure(6, f, lat, p, w, gi, gb, ib);
`ifdef IRQ_TRIG_REARM_EN
        exp_fire++;
        total++; if (f !== 1'b1 || p !== 6'b000001) $display("FAIL rearm_second: got pat=%b expected 000001", p); else passed++;
`else
        total++; if (f !== 1'b0) $display("FAIL rearm_ignored: got pulse %b expected none", p); else passed++;
`endif
        total++; if (fire_cnt !== 16'(exp_fire)) $display("FAIL rearm_fire_cnt: got %0d expected %0d", fire_cnt, exp_fire); else passed++;
    endtask

    task automatic test_reset_mid();
        bit f, gb, ib; int lat, w; logic [5:0] p, gi;
        load(8, 32'h3600, 1, 10);
        present(32'h3600);
        tick();
        total++; if (irq_o !== 6'b000010) $display("FAIL mid_rise: got %b expected 000010", irq_o); else passed++;
        tick();
        tick();
        reset = 1'b1;
        tick();
        total++; if (irq_o !== 6'h0 || busy !== 1'b0) $display("FAIL mid_reset_out: got irq=%b busy=%0d expected 000000 0", irq_o, busy); else passed++;
        total++; if (fire_cnt !== 16'd0 || hit_idx !== 4'd0) $display("FAIL mid_reset_cnt: got fire=%0d hit=%0d expected 0 0", fire_cnt, hit_idx); else passed++;
        reset = 1'b0;
        tick();
        present(32'h3600);
        measure(5, f, lat, p, w, gi, gb, ib);
        total++; if (f !== 1'b0 || fire_cnt !== 16'd0) $display("FAIL mid_table_cleared: got pulse=%b fire=%0d expected none 0", p, fire_cnt); else passed++;
    endtask

    initial begin
        reset = 1'b1; addr_i = '0; arm = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_valid = 1'b0; cfg_addr = '0; cfg_chan = '0; cfg_len = '0; rearm = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_len();
        test_arm();
        test_same_cycle();
        test_rearm();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
